// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the free-running counter block.
//
//   Contents:
//     COUNTER_DEFAULT_WIDTH : default bit width of the count register
//
//   Configuration macro affecting users of this package:
//     COUNTER_SATURATE_EN (see rtl/counter.sv)
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 8;

endpackage : counter_pkg

// File: rtl/counter.sv
// counter
//   Free-running unsigned up-counter with terminal-count decode and a
//   registered rollover pulse.
//
//   Parameters:
//     WIDTH  : count width in bits, legal range 2..32
//
//   Ports:
//     clk    : input,  single clock, all state changes on its rising edge
//     rst_n  : input,  synchronous active-low reset (clears out and wrap)
//     out    : output, WIDTH bits, current count straight from the register
//     tc     : output, combinational terminal count, high while out is all ones
//     wrap   : output, registered one-cycle pulse in the cycle where out
//              holds the zero produced by a rollover
//
//   Configuration:
//     COUNTER_SATURATE_EN defined   -> the count sticks at all ones and
//                                      wrap never asserts
//     COUNTER_SATURATE_EN undefined -> all ones rolls over to zero and
//                                      wrap pulses for one cycle
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  typedef logic [WIDTH-1:0] count_t;

  count_t count_q;
  count_t count_d;
  count_t incr;
  logic   carry;
  logic   wrap_q;
  logic   wrap_d;

  // Next-state logic. The incrementer is one bit wider than the count so the
  // carry-out falls out for free; the carry is high exactly when the current
  // count is all ones, which is the only case that rolls over.
  always_comb begin
    {carry, incr} = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    count_d = incr;
    wrap_d  = carry;
`ifdef COUNTER_SATURATE_EN
    // Saturating build: instead of rolling over, hold at all ones.
    wrap_d = 1'b0;
    if (carry) begin
      count_d = count_q;
    end
`endif
  end

  // State registers. Reset is sampled only on the clock edge, so a low pulse
  // on rst_n that does not span a rising edge leaves the count untouched.
  // Reset wins over counting, including at all ones, so no wrap is produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = count_q;
  assign tc   = &count_q;
  assign wrap = wrap_q;

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter
//   Scoreboard bench for counter. Stimulus drives rst_n once per clock
//   (2 ns after each rising edge) and pushes the response the reference
//   model predicts for the following rising edge; a monitor on the falling
//   edge pops and compares out, wrap and tc.
//
//   Honours COUNTER_SATURATE_EN in its reference model.
module tb_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  typedef struct {
    int   out;
    logic wrap;
    logic tc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;

  exp_t expQ[$];
  int   assertCount;
  int   failCount;
  int   modelCount;

  counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .out  (out),
    .tc   (tc),
    .wrap (wrap)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model step for one rising edge, followed by pushing the
  // predicted outputs. Expressed as plain integer arithmetic on the count.
  task automatic predict(input logic rstVal);
    exp_t e;
    if (!rstVal) begin
      modelCount = 0;
      e.wrap     = 1'b0;
    end else begin
`ifdef COUNTER_SATURATE_EN
      if (modelCount != MAXV) modelCount = modelCount + 1;
      e.wrap = 1'b0;
`else
      e.wrap     = (modelCount == MAXV);
      modelCount = (modelCount + 1) % (MAXV + 1);
`endif
    end
    e.out = modelCount;
    e.tc  = (modelCount == MAXV);
    expQ.push_back(e);
  endtask

  // Drive rst_n for the next rising edge (optionally with a short low glitch
  // that ends well before that edge), record the prediction, then advance to
  // 2 ns past that edge.
  task automatic applyStimulus(input logic rstVal, input bit glitch);
    if (glitch) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      predict(1'b1);
    end else begin
      rst_n = rstVal;
      predict(rstVal);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic runCycles(input int n, input logic rstVal);
    for (int i = 0; i < n; i++) applyStimulus(rstVal, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    assertCount++;
    if (out !== WIDTH'(e.out)) begin
      failCount++;
      $display("[TB] FAIL out: got %0d expected %0d at %0t", out, e.out, $time);
    end
    assertCount++;
    if (wrap !== e.wrap) begin
      failCount++;
      $display("[TB] FAIL wrap: got %b expected %b (out=%0d) at %0t", wrap, e.wrap, out, $time);
    end
    assertCount++;
    if (tc !== e.tc) begin
      failCount++;
      $display("[TB] FAIL tc: got %b expected %b (out=%0d) at %0t", tc, e.tc, out, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge
  // against the oldest outstanding prediction.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    modelCount  = 0;
    rst_n       = 1'b0;

    // Reset for the 5 and 15 ns edges, then count ten edges (out=10 at 115 ns).
    runCycles(2, 1'b0);
    runCycles(10, 1'b1);

    // Mid-run reset over two edges, then eight counting edges.
    runCycles(2, 1'b0);
    runCycles(8, 1'b1);

    // Long run from zero: rollover (or saturation) and the cycles around it.
    runCycles(1, 1'b0);
    runCycles(300, 1'b1);

    // Reset exactly on the edge where the count would leave all ones.
    runCycles(1, 1'b0);
    runCycles(MAXV, 1'b1);
    runCycles(1, 1'b0);
    runCycles(3, 1'b1);

    // Short rst_n glitches between edges must not disturb the count.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
    end

    // Randomized reset pattern with occasional long runs.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 15) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
- REQ-001 Parameter: WIDTH, default 8, counter bit width; legal range 2..32.
- REQ-002 Port: clk, input, 1 bit; single clock; all state updates on its rising edge.
- REQ-003 Port: rst_n, input, 1 bit; reset is synchronous and active-low.
- REQ-004 Port: out, output, WIDTH bits; current count, driven directly from a register.
- REQ-005 Port: tc, output, 1 bit; terminal count; combinational, high when out equals all ones.
- REQ-006 Port: wrap, output, 1 bit; registered one-cycle pulse; high in the cycle after out rolls from all ones to zero.
- REQ-007 The block SHALL have no other inputs, so an instance connecting only clk, rst_n and out is fully defined.

Function
- REQ-008 Rising edge of clk with rst_n high: out SHALL become out+1 modulo 2^WIDTH.
- REQ-009 Latency: out SHALL change exactly once per rising edge, never between edges.
- REQ-010 Wrap-around, default build: all ones SHALL be followed by zero on the next edge, with no stall cycle.
- REQ-011 wrap SHALL be 1 for exactly the one cycle in which out holds the zero produced by a rollover, and 0 otherwise.
- REQ-012 tc SHALL equal the AND of all out bits; it SHALL be combinational from out only.
- REQ-013 Arithmetic: the increment SHALL be unsigned WIDTH-bit; the carry-out SHALL be discarded except to generate wrap.

Reset
- REQ-014 On a rising edge with rst_n low, out SHALL become 0 and wrap SHALL become 0.
- REQ-015 Therefore tc SHALL be 0 after reset.
- REQ-016 Reset SHALL take priority over counting, including a reset asserted while the count is all ones; no wrap pulse is produced in that case.
- REQ-017 Reset SHALL NOT act asynchronously: an rst_n low pulse that covers no rising edge SHALL have no effect.
- REQ-018 On the first rising edge after rst_n returns high, out SHALL become 1.
- REQ-019 The only reset path SHALL be rst_n; registers need no power-on initial value beyond that.

Configuration
- REQ-020 Macro COUNTER_SATURATE_EN, defined: at all ones, out SHALL hold all ones on further edges instead of wrapping, and wrap SHALL stay 0 permanently.
- REQ-021 Macro COUNTER_SATURATE_EN, undefined: wrapping behaviour per REQ-010 and REQ-011.
- REQ-022 tc and reset behaviour SHALL be identical in both builds.

Structure
- REQ-023 Shared package counter_pkg SHALL hold the constant COUNTER_DEFAULT_WIDTH = 8, which serves as the WIDTH default.
- REQ-024 No typedefs are required beyond a WIDTH-wide count type defined locally.
- REQ-025 The block SHALL be a single module with no sub-module; the count register, incrementer, tc decode and wrap flop are all inline.

Verification (clk period 10 ns, first rising edge at 5 ns)
- REQ-026 Reset then count: rst_n=0 for 0–20 ns, then 1 -> out=0 at the 5 and 15 ns edges, out=1 at 25 ns, and out=10 after the 115 ns edge.
- REQ-027 Mid-run reset: rst_n=0 from 120 to 140 ns -> out=0 at the 125 and 135 ns edges; after release, out=1 at 145 ns and out=8 at 215 ns.
- REQ-028 Rollover, default build, WIDTH=8: count from 0 for 256 edges -> tc=1 while out=255, out=0 with wrap=1 for exactly one cycle, then out=1 with wrap=0.
- REQ-029 Saturation, build with COUNTER_SATURATE_EN: 300 edges after reset -> out=255 and tc=1 from edge 255 onward, and wrap never asserts.
- REQ-030 Reset at terminal count: assert rst_n=0 on the edge where out would go 255->0 -> out=0, wrap=0, tc=0.
- REQ-031 Glitch immunity: an rst_n low pulse of 2 ns placed between edges -> count continues uninterrupted.
